irrigation_bcd_timer: RTL

Parametrised mm:ss BCD timer for the residential irrigation controller: loads a watering duration, counts it down (or counts elapsed time up) at a 1 Hz tick derived from the system clock, and flags completion. It replaces the fixed single-digit mod-6/mod-10 counter chain with a generic, pausable, loadable cascade. Digit outputs drive the display decoders. `running` and `done` go to the valve sequencer.

---
 rtl/irrigation_timer_pkg.sv | 21 ++
 rtl/irrigation_bcd_timer_bcd_digit.sv | 40 ++++
 rtl/irrigation_bcd_timer.sv | 115 +++++++++++
 3 files changed

// File: rtl/irrigation_timer_pkg.sv
// Shared types, limits and preset sanitising for the irrigation mm:ss BCD timer.
package irrigation_timer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED,
        DONE
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX      = 4'd9;
    localparam bcd_t SEC_TENS_MAX = 4'd5;

    // Out-of-range preset nibbles are clamped to the digit's own maximum.
    function automatic bcd_t sanitise(input bcd_t value, input bcd_t max);
        return (value > max) ? max : value;
    endfunction

endpackage

// File: rtl/irrigation_bcd_timer_bcd_digit.sv
// One loadable up/down BCD digit of the timer cascade with ripple carry/borrow.
module bcd_digit
    import irrigation_timer_pkg::*;
#(
    parameter bcd_t MAX = BCD_MAX
) (
    input  logic clk,
    input  logic clear_n,
    input  logic step,
    input  logic up,
    input  logic cin,
    input  logic load,
    input  bcd_t load_value,
    output bcd_t value,
    output logic cout,
    output logic at_zero,
    output logic at_max
);

    always_comb begin
        at_zero = (value == '0);
        at_max  = (value == MAX);
        cout    = cin && (up ? at_max : at_zero);
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            value <= '0;
        end else if (load) begin
            value <= sanitise(load_value, MAX);
        end else if (step && cin) begin
            if (up) begin
                value <= at_max ? '0 : value + 4'd1;
            end else begin
                value <= at_zero ? MAX : value - 4'd1;
            end
        end
    end

endmodule

// File: rtl/irrigation_bcd_timer.sv
// Pausable, loadable mm:ss BCD countdown/count-up timer with a 1 Hz prescaler,
// driving the display digits and the valve sequencer's running/done flags.
module irrigation_bcd_timer
    import irrigation_timer_pkg::*;
#(
    parameter int TICK_DIV   = 50_000_000,
    parameter int MIN_DIGITS = 2
) (
    input  logic                        clk,
    input  logic                        clear_n,
    input  logic                        load,
    input  logic [4*(MIN_DIGITS+2)-1:0] preset,
    input  logic                        start,
    input  logic                        pause,
    input  logic                        mode_up,
    output logic [4*(MIN_DIGITS+2)-1:0] digits,
    output logic                        running,
    output logic                        sec_pulse,
    output logic                        done
);

    localparam int N  = MIN_DIGITS + 2;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    state_t        state;
    logic [PW-1:0] presc;
    logic          dir_up;
    logic [N:0]    chain;
    logic [N-1:0]  at_zero;
    logic [N-1:0]  at_max;
    logic          pause_run;
    logic          start_ok;
    logic          tick;
    logic          step;
    logic          all_zero;
    logic          all_max;
    logic          last_step;

    assign chain[0] = 1'b1;

    for (genvar i = 0; i < N; i++) begin : g_digit
        localparam bcd_t DMAX = (i == 1) ? SEC_TENS_MAX : BCD_MAX;
        bcd_digit #(.MAX(DMAX)) u_digit (
            .clk        (clk),
            .clear_n    (clear_n),
            .step       (step),
            .up         (dir_up),
            .cin        (chain[i]),
            .load       (load),
            .load_value (preset[4*i +: 4]),
            .value      (digits[4*i +: 4]),
            .cout       (chain[i+1]),
            .at_zero    (at_zero[i]),
            .at_max     (at_max[i])
        );
    end

    always_comb begin
        pause_run = pause && (state == RUN);
        start_ok  = start && ((state == IDLE) || (state == PAUSED));
        all_zero  = &at_zero;
        all_max   = &at_max;
        // chain[N] means every digit already sits at its limit; such a count never steps.
        tick      = (state == RUN) && (presc == PW'(TICK_DIV - 1)) && !chain[N];
        step      = tick && !load && !pause_run;
        // The step about to happen lands on the terminal value: ..:01 going down, 9..9:58 going up.
        last_step = dir_up ? ((digits[3:0] == BCD_MAX - 4'd1) && (&at_max[N-1:1]))
                           : ((digits[3:0] == 4'd1) && (&at_zero[N-1:1]));
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state     <= IDLE;
            presc     <= '0;
            dir_up    <= 1'b0;
            running   <= 1'b0;
            sec_pulse <= 1'b0;
            done      <= 1'b0;
        end else begin
            sec_pulse <= 1'b0;
            done      <= 1'b0;
            if (load) begin
                state   <= IDLE;
                presc   <= '0;
                running <= 1'b0;
            end else if (pause_run) begin
                state   <= PAUSED;
                running <= 1'b0;
            end else if (start_ok) begin
                dir_up <= mode_up;
                if (mode_up ? all_max : all_zero) begin
                    state   <= DONE;
                    running <= 1'b0;
                    done    <= 1'b1;
                end else begin
                    state   <= RUN;
                    running <= 1'b1;
                end
            end else if (state == RUN) begin
                if (tick) begin
                    presc     <= '0;
                    sec_pulse <= 1'b1;
                    if (last_step) begin
                        state   <= DONE;
                        running <= 1'b0;
                        done    <= 1'b1;
                    end
                end else begin
                    presc <= presc + PW'(1);
                end
            end
        end
    end

endmodule
